load_store_unit: RTL

- Initiator side of the byte-addressed, big-endian, word-wide data memory interface.
- Sits between the core's execute stage and the data memory.
- Accepts one load/store request at a time and drives the memory's address, write data, write strobe and read strobe.
- Sub-word stores are done as read-modify-write. Loaded data is sign- or zero-extended before it is returned to the core.

---
 rtl/lsu_pkg.sv | 21 ++
 rtl/lsu_lane_align.sv | 46 ++++
 rtl/load_store_unit.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared encodings and byte-lane helper for the load/store unit
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        MERGE,
        WRITE,
        RESP
    } state_t;

    // Big-endian lane: byte at offset k lives in bits [31-8k : 24-8k].
    function automatic logic [4:0] lane_lsb(input logic [1:0] offset);
        return 5'd24 - {offset, 3'b000};
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - big-endian store merge and load extract/extend
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_signed,
    input  logic [31:0] wdata,
    output logic [31:0] merged,
    output logic [31:0] loaded
);

    logic [4:0]  byte_lsb;
    logic [4:0]  half_lsb;
    logic [7:0]  byte_val;
    logic [15:0] half_val;

    // Select the lanes addressed by the offset; a halfword's low byte sits at offset|1.
    always_comb begin
        byte_lsb = lane_lsb(offset);
        half_lsb = lane_lsb({offset[1], 1'b1});
        byte_val = word[byte_lsb +: 8];
        half_val = word[half_lsb +: 16];
    end

    // Insert new store bytes into the word read back from memory.
    always_comb begin
        merged = word;
        case (size)
            SZ_BYTE: merged[byte_lsb +: 8]  = wdata[7:0];
            SZ_HALF: merged[half_lsb +: 16] = wdata[15:0];
            default: merged = wdata;
        endcase
    end

    // Extract the addressed bytes and extend; word loads pass through untouched.
    always_comb begin
        case (size)
            SZ_BYTE: loaded = {{24{is_signed & byte_val[7]}}, byte_val};
            SZ_HALF: loaded = {{16{is_signed & half_val[15]}}, half_val};
            default: loaded = word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store initiator with read-modify-write sub-word stores
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_BYTES = 200,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [31:0]       mem_rdata
);

    localparam int AW1 = ADDR_W + 1;

    state_t      state;
    state_t      next_state;

    logic [1:0]  offset_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic        write_q;
    logic        err_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;

    logic [1:0]  nbytes_m1;
    logic [ADDR_W:0] last_byte;
    logic        req_err;
    logic [31:0] merged;
    logic [31:0] loaded;

    lsu_lane_align u_lane_align (
        .word      (rdata_q),
        .offset    (offset_q),
        .size      (size_q),
        .is_signed (signed_q),
        .wdata     (wdata_q),
        .merged    (merged),
        .loaded    (loaded)
    );

    // Classify the incoming request; the extra address bit keeps the range test from wrapping.
    always_comb begin
        case (req_size)
            SZ_BYTE: nbytes_m1 = 2'd0;
            SZ_HALF: nbytes_m1 = 2'd1;
            default: nbytes_m1 = 2'd3;
        endcase
        last_byte = {1'b0, req_addr} + AW1'(nbytes_m1);
        req_err   = (req_size == 2'b11)
                  | ((req_size == SZ_HALF) & req_addr[0])
                  | ((req_size == SZ_WORD) & (req_addr[1:0] != 2'b00))
                  | (last_byte >= AW1'(MEM_BYTES));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake/strobe outputs; strobes are gated so a reset cycle never commits.
    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = 32'd0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_err) begin
                        next_state = RESP;
                    end else if (req_write && (req_size == SZ_WORD)) begin
                        next_state = WRITE;
                    end else begin
                        next_state = READ;
                    end
                end
            end
            READ: begin
                mem_read   = !reset;
                next_state = write_q ? MERGE : RESP;
            end
            MERGE: begin
                next_state = WRITE;
            end
            WRITE: begin
                mem_write  = !reset;
                next_state = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                resp_rdata = (err_q || write_q) ? 32'd0 : loaded;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Capture the request, the read-back word and the merged store word.
    always_ff @(posedge clk) begin
        if (reset) begin
            offset_q  <= 2'd0;
            size_q    <= 2'd0;
            signed_q  <= 1'b0;
            write_q   <= 1'b0;
            err_q     <= 1'b0;
            wdata_q   <= 32'd0;
            rdata_q   <= 32'd0;
            mem_addr  <= '0;
            mem_wdata <= 32'd0;
        end else begin
            if (state == IDLE && req_valid) begin
                offset_q <= req_addr[1:0];
                size_q   <= req_size;
                signed_q <= req_signed;
                write_q  <= req_write;
                err_q    <= req_err;
                wdata_q  <= req_wdata;
                if (!req_err) begin
                    mem_addr <= {req_addr[ADDR_W-1:2], 2'b00};
                    if (req_write && (req_size == SZ_WORD)) begin
                        mem_wdata <= req_wdata;
                    end
                end
            end
            if (state == READ) begin
                rdata_q <= mem_rdata;
            end
            if (state == MERGE) begin
                mem_wdata <= merged;
            end
        end
    end

endmodule
